sprite_plot_scheduler: RTL and testbench

Frame-synchronous scheduler that shares the single VGA pixel-write port among up to NUM_REQ sprite drawers (birds, hunter, laser). On each frame tick it walks the enabled requesters in ascending index order. For each one it runs an erase pass (colour forced to 0), then a draw pass (requester colour). It muxes the active requester's pixel stream onto the plot port. It sits between the sprite drawers and the VGA adapter and replaces the hard-coded per-bird state list.

---
 rtl/sprite_plot_scheduler_if.sv | 37 +++
 rtl/sprite_plot_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_plot_scheduler_if.sv
// Bundle of the signals between sprite_plot_scheduler and the outside world.
//   slave  : scheduler side (takes tick/enable/requester pixels, drives start/erase/plot/status)
//   master : environment side (sprite drawers, frame timer, VGA adapter)
// Requester vectors are flattened; slot i lives at [i*W +: W].
interface sprite_plot_scheduler_if #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3
);
  logic                         frame_tick;
  logic [NUM_REQ-1:0]           enable;
  logic [NUM_REQ-1:0]           start;
  logic                         erase;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*X_W-1:0]       req_x;
  logic [NUM_REQ*Y_W-1:0]       req_y;
  logic [NUM_REQ*COLOUR_W-1:0]  req_colour;
  logic [NUM_REQ-1:0]           done;
  logic                         plot;
  logic [X_W-1:0]               plot_x;
  logic [Y_W-1:0]               plot_y;
  logic [COLOUR_W-1:0]          plot_colour;
  logic                         busy;
  logic                         frame_overrun;
  logic                         timeout_err;

  modport slave (
    input  frame_tick, enable, req_valid, req_x, req_y, req_colour, done,
    output start, erase, plot, plot_x, plot_y, plot_colour, busy, frame_overrun, timeout_err
  );

  modport master (
    output frame_tick, enable, req_valid, req_x, req_y, req_colour, done,
    input  start, erase, plot, plot_x, plot_y, plot_colour, busy, frame_overrun, timeout_err
  );
endinterface

// File: rtl/sprite_plot_scheduler.sv
// Frame-synchronous scheduler sharing the single VGA pixel-write port among
// NUM_REQ sprite drawers. Each accepted frame_tick walks the enabled slots in
// ascending order; each slot gets an erase pass (colour 0) then a draw pass.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : frame_tick/enable in, per-slot start out, shared erase out,
//                  requester pixel streams + done in, muxed plot port out,
//                  busy / frame_overrun / timeout_err status out
module sprite_plot_scheduler #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic                   clock,
  input  logic                   reset,
  sprite_plot_scheduler_if.slave bus
);
  // idx must reach NUM_REQ without wrapping
  localparam int unsigned IDX_W = $clog2(NUM_REQ + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_REQ);
  // the counter holds (cycles spent - 1), so this value marks the TIMEOUT-th cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEEK    = 3'd1;
  localparam logic [2:0] START_E = 3'd2;
  localparam logic [2:0] ERASE   = 3'd3;
  localparam logic [2:0] START_D = 3'd4;
  localparam logic [2:0] DRAW    = 3'd5;

  logic [2:0]         state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [NUM_REQ-1:0] mask, mask_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_REQ-1:0] start_q, start_next;
  logic               busy_q, overrun_q, timeout_q, timeout_set;

  logic                sel_mask, sel_done, sel_valid;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_colour;

  // Select the active slot's signals; idx==NUM_REQ selects nothing.
  always_comb begin
    sel_mask   = 1'b0;
    sel_done   = 1'b0;
    sel_valid  = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(idx) == i) begin
        sel_mask   = mask[i];
        sel_done   = bus.done[i];
        sel_valid  = bus.req_valid[i];
        sel_x      = bus.req_x[i*X_W +: X_W];
        sel_y      = bus.req_y[i*Y_W +: Y_W];
        sel_colour = bus.req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    mask_next   = mask;
    cnt_next    = '0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_tick) begin
          mask_next  = bus.enable;
          idx_next   = '0;
          state_next = SEEK;
        end
      end
      SEEK: begin
        if (idx == IDX_END) begin
          state_next = IDLE;
        end else if (sel_mask) begin
          state_next = START_E;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      // done is deliberately not looked at in the START states
      START_E: state_next = ERASE;
      START_D: state_next = DRAW;
      ERASE, DRAW: begin
        if (sel_done) begin
          if (state == ERASE) begin
            state_next = START_D;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = SEEK;
          end
        end else if (cnt == CNT_LAST) begin
          // abandon this slot entirely, including any pending draw pass
          timeout_set = 1'b1;
          idx_next    = idx + 1'b1;
          state_next  = SEEK;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // start is registered, so it is decoded from the state being entered
    start_next = '0;
    if (state_next == START_E || state_next == START_D) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (32'(idx_next) == i) start_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      mask      <= '0;
      cnt       <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      mask      <= mask_next;
      cnt       <= cnt_next;
      start_q   <= start_next;
      busy_q    <= (state_next != IDLE);
      overrun_q <= bus.frame_tick && (state != IDLE);
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  // Zero-latency pixel pass-through of the active slot.
  always_comb begin
    bus.plot        = 1'b0;
    bus.plot_x      = '0;
    bus.plot_y      = '0;
    bus.plot_colour = '0;
    if (state == ERASE || state == DRAW) begin
      bus.plot   = sel_valid;
      bus.plot_x = sel_x;
      bus.plot_y = sel_y;
      if (state == DRAW) bus.plot_colour = sel_colour;
    end
  end

  assign bus.erase         = (state == START_E) || (state == ERASE);
  assign bus.start         = start_q;
  assign bus.busy          = busy_q;
  assign bus.frame_overrun = overrun_q;
  assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed testbench for sprite_plot_scheduler (NUM_REQ=8, TIMEOUT=63).
module tb_sprite_plot_scheduler;
  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  sprite_plot_scheduler_if #(.NUM_REQ(8), .X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

  sprite_plot_scheduler #(
    .NUM_REQ(8), .X_W(8), .Y_W(7), .COLOUR_W(3), .TIMEOUT(63)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // n cycles in SEEK: busy, nothing started, nothing plotted
  task automatic seek(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      nxt();
      #1;
      chk("seek_busy", 32'(bus.busy), 32'h1);
      chk("seek_start", 32'(bus.start), 32'h0);
      chk("seek_plot", 32'(bus.plot), 32'h0);
    end
  endtask

  // One pass of a requester that drops done on start, emits npix pixels, then raises done.
  task automatic pass(input int unsigned slot, input bit era, input int unsigned npix,
                      input logic [2:0] col, input logic [7:0] x0, input logic [6:0] y0);
    for (int unsigned k = 0; k < npix; k++) begin
      nxt();
      bus.done[slot]                = 1'b0;
      bus.req_valid[slot]           = 1'b1;
      bus.req_x[slot*8 +: 8]        = x0 + 8'(k);
      bus.req_y[slot*7 +: 7]        = y0 + 7'(k);
      bus.req_colour[slot*3 +: 3]   = col;
      #1;
      chk("pix_plot", 32'(bus.plot), 32'h1);
      chk("pix_x", 32'(bus.plot_x), 32'(x0 + 8'(k)));
      chk("pix_y", 32'(bus.plot_y), 32'(y0 + 7'(k)));
      chk("pix_colour", 32'(bus.plot_colour), era ? 32'h0 : 32'(col));
      chk("pix_erase", 32'(bus.erase), 32'(era));
      chk("pix_start", 32'(bus.start), 32'h0);
    end
    nxt();
    bus.req_valid[slot] = 1'b0;
    bus.done[slot]      = 1'b1;
    #1;
    chk("done_plot", 32'(bus.plot), 32'h0);
    chk("done_erase", 32'(bus.erase), 32'(era));
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.enable     = '0;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    bus.done       = '0;

    // ---- reset state
    nxt();
    nxt();
    #1;
    chk("rst_start", 32'(bus.start), 32'h0);
    chk("rst_erase", 32'(bus.erase), 32'h0);
    chk("rst_plot", 32'(bus.plot), 32'h0);
    chk("rst_xyc", 32'({bus.plot_x, bus.plot_y, bus.plot_colour}), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_overrun", 32'(bus.frame_overrun), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'h0);
    nxt();
    reset = 1'b0;

    // ---- single requester, 13 pixels, done held high before start
    nxt();
    bus.enable     = 8'h01;
    bus.frame_tick = 1'b1;
    bus.done       = 8'h01;
    #1;
    chk("a_idle_busy", 32'(bus.busy), 32'h0);
    nxt();
    bus.frame_tick = 1'b0;
    #1;
    chk("a_seek_busy", 32'(bus.busy), 32'h1);
    chk("a_seek_start", 32'(bus.start), 32'h0);
    nxt();
    #1;
    chk("a_starte", 32'(bus.start), 32'h01);
    chk("a_starte_erase", 32'(bus.erase), 32'h1);
    chk("a_starte_plot", 32'(bus.plot), 32'h0);
    pass(0, 1'b1, 13, 3'b111, 8'd10, 7'd20);
    nxt();
    #1;
    chk("a_startd", 32'(bus.start), 32'h01);
    chk("a_startd_erase", 32'(bus.erase), 32'h0);
    pass(0, 1'b0, 13, 3'b111, 8'd10, 7'd20);
    seek(8);
    nxt();
    #1;
    chk("a_end_busy", 32'(bus.busy), 32'h0);

    // ---- mask 0x55, odd slots hold valid high with distinct coordinates
    bus.done       = '0;
    bus.req_valid  = 8'hAA;
    bus.req_x      = {8{8'hEE}};
    bus.req_y      = {8{7'h7E}};
    bus.req_colour = {8{3'd5}};
    nxt();
    bus.enable     = 8'h55;
    bus.frame_tick = 1'b1;
    #1;
    chk("b_idle_plot", 32'(bus.plot), 32'h0);
    nxt();
    bus.frame_tick = 1'b0;
    #1;
    chk("b_seek0_plot", 32'(bus.plot), 32'h0);
    for (int unsigned s = 0; s < 8; s += 2) begin
      if (s != 0) seek(2);
      nxt();
      #1;
      chk("b_starte", 32'(bus.start), 32'h1 << s);
      pass(s, 1'b1, 2, 3'(s + 1), 8'(16 * s), 7'(8 * s));
      nxt();
      #1;
      chk("b_startd", 32'(bus.start), 32'h1 << s);
      pass(s, 1'b0, 2, 3'(s + 1), 8'(16 * s), 7'(8 * s));
    end
    seek(2);
    nxt();
    #1;
    chk("b_end_busy", 32'(bus.busy), 32'h0);

    // ---- slot 1 never finishes: 63 ERASE cycles, then slot 2
    bus.done      = '0;
    bus.req_valid = '0;
    nxt();
    bus.enable     = 8'h06;
    bus.frame_tick = 1'b1;
    #1;
    nxt();
    bus.frame_tick = 1'b0;
    #1;
    nxt();
    #1;
    chk("c_seek1_start", 32'(bus.start), 32'h0);
    nxt();
    #1;
    chk("c_starte1", 32'(bus.start), 32'h02);
    for (int unsigned k = 0; k < 63; k++) begin
      nxt();
      #1;
      chk("c_erase_hold", 32'(bus.erase), 32'h1);
      chk("c_erase_noerr", 32'(bus.timeout_err), 32'h0);
    end
    nxt();
    #1;
    chk("c_abort_erase", 32'(bus.erase), 32'h0);
    chk("c_abort_start", 32'(bus.start), 32'h0);
    chk("c_timeout_err", 32'(bus.timeout_err), 32'h1);
    nxt();
    #1;
    chk("c_starte2", 32'(bus.start), 32'h04);
    pass(2, 1'b1, 3, 3'd6, 8'd100, 7'd60);
    nxt();
    #1;
    chk("c_startd2", 32'(bus.start), 32'h04);
    pass(2, 1'b0, 3, 3'd6, 8'd100, 7'd60);
    seek(6);
    nxt();
    #1;
    chk("c_end_busy", 32'(bus.busy), 32'h0);

    // ---- frame_tick while busy is dropped and flagged
    bus.done = '0;
    nxt();
    bus.enable     = 8'h01;
    bus.frame_tick = 1'b1;
    #1;
    nxt();
    bus.frame_tick = 1'b0;
    #1;
    nxt();
    bus.frame_tick = 1'b1;
    #1;
    chk("d_starte", 32'(bus.start), 32'h01);
    chk("d_no_overrun_yet", 32'(bus.frame_overrun), 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      nxt();
      bus.frame_tick    = 1'b0;
      bus.done[0]       = 1'b0;
      bus.req_valid[0]  = 1'b1;
      bus.req_x[7:0]    = 8'd40 + 8'(k);
      bus.req_y[6:0]    = 7'd50 + 7'(k);
      bus.req_colour[2:0] = 3'd2;
      #1;
      chk("d_pix_plot", 32'(bus.plot), 32'h1);
      chk("d_pix_x", 32'(bus.plot_x), 32'(8'd40 + 8'(k)));
      chk("d_overrun", 32'(bus.frame_overrun), (k == 0) ? 32'h1 : 32'h0);
    end
    nxt();
    bus.req_valid[0] = 1'b0;
    bus.done[0]      = 1'b1;
    #1;
    chk("d_done_plot", 32'(bus.plot), 32'h0);
    nxt();
    #1;
    chk("d_startd", 32'(bus.start), 32'h01);
    pass(0, 1'b0, 3, 3'd2, 8'd40, 7'd50);
    seek(8);
    nxt();
    bus.done       = '0;
    bus.enable     = 8'h08;
    bus.frame_tick = 1'b1;
    #1;
    chk("d_idle_busy", 32'(bus.busy), 32'h0);
    chk("d_sticky_err", 32'(bus.timeout_err), 32'h1);
    nxt();
    bus.frame_tick = 1'b0;
    #1;
    chk("d_accept_busy", 32'(bus.busy), 32'h1);
    chk("d_accept_no_overrun", 32'(bus.frame_overrun), 32'h0);
    seek(3);
    nxt();
    #1;
    chk("e_starte3", 32'(bus.start), 32'h08);
    pass(3, 1'b1, 2, 3'd4, 8'd200, 7'd100);
    nxt();
    #1;
    chk("e_startd3", 32'(bus.start), 32'h08);

    // ---- reset during DRAW of slot 3
    nxt();
    bus.done[3]         = 1'b0;
    bus.req_valid[3]    = 1'b1;
    bus.req_x[31:24]    = 8'd77;
    bus.req_y[27:21]    = 7'd33;
    bus.req_colour[11:9] = 3'd4;
    reset               = 1'b1;
    #1;
    chk("e_draw_plot", 32'(bus.plot), 32'h1);
    chk("e_draw_colour", 32'(bus.plot_colour), 32'h4);
    nxt();
    #1;
    chk("e_rst_plot", 32'(bus.plot), 32'h0);
    chk("e_rst_busy", 32'(bus.busy), 32'h0);
    chk("e_rst_start", 32'(bus.start), 32'h0);
    chk("e_rst_erase", 32'(bus.erase), 32'h0);
    chk("e_rst_timeout", 32'(bus.timeout_err), 32'h0);
    nxt();
    reset         = 1'b0;
    bus.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
